// File: rtl/apb_subsystem.sv
// apb_subsystem
//   Single-master APB fabric. A host request (transfer/write/addr/wdata) is
//   turned into one APB SETUP/ACCESS transaction. The address page
//   addr[31:12] selects one of five slots:
//     0x10000 -> slot 0: 16-word RAM, zero wait states
//     0x10001 -> slot 1: four-register peripheral A, one wait state
//     0x10002 -> slot 2: four-register peripheral B, one wait state
//     0x10003/4 -> slots 3/4: unpopulated, PSEL asserted, default response
//     any other page -> unmapped, no PSEL, default response
//
// Ports
//   PCLK      in   system clock, rising edge
//   PRESET    in   asynchronous active-high reset
//   transfer  in   request strobe, sampled only while the master is idle
//   write     in   1 = write, 0 = read (captured with transfer)
//   addr      in   byte address (captured with transfer)
//   wdata     in   write data (captured with transfer)
//   ready     out  one-cycle completion pulse
//   rdata     out  read data while ready=1 on a read, otherwise 0
module apb_subsystem #(
  parameter int RAM_WORDS = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        transfer,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata
);

  localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t      state_q, state_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        pwrite_q, pwrite_d;

  logic [4:0]  slot_hit;
  logic [4:0]  psel;
  logic        penable;
  logic        pready_mux;
  logic [31:0] prdata_mux;

  // Page decode of the held address; at most one bit set.
  always_comb begin
    slot_hit = '0;
    case (paddr_q[31:12])
      20'h10000: slot_hit = 5'b00001;
      20'h10001: slot_hit = 5'b00010;
      20'h10002: slot_hit = 5'b00100;
      20'h10003: slot_hit = 5'b01000;
      20'h10004: slot_hit = 5'b10000;
      default:   slot_hit = '0;
    endcase
  end

  assign psel    = (state_q == S_IDLE) ? 5'b00000 : slot_hit;
  assign penable = (state_q == S_ACCESS);

  // ---------------------------------------------------------------- RAM
  // Contents deliberately survive reset; byte offset and bits above the
  // word index are ignored so the array aliases every RAM_WORDS*4 bytes.
  logic [31:0]       ram_mem [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx;
  logic              ram_we;

  assign ram_idx = paddr_q[RAM_AW+1:2];
  assign ram_we  = psel[0] & penable & pwrite_q;

  always_ff @(posedge PCLK) begin
    if (ram_we) begin
      ram_mem[ram_idx] <= pwdata_q;
    end
  end

  // ------------------------------------------------- register peripherals
  logic [1:0]  per_pready;
  logic [31:0] per_prdata [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_per
    logic [31:0] regs_q [4];
    logic [31:0] regs_d [4];
    logic        pready_q, pready_d;
    logic        sel_acc;

    assign sel_acc = psel[gi+1] & penable;

    // pready_q rises after the first ACCESS cycle, giving exactly one wait
    // state, and self-clears on the completing edge.
    always_comb begin
      pready_d = sel_acc & ~pready_q;
      for (int i = 0; i < 4; i++) begin
        regs_d[i] = regs_q[i];
      end
      if (sel_acc & pready_q & pwrite_q) begin
        regs_d[paddr_q[3:2]] = pwdata_q;
      end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
        pready_q <= 1'b0;
        for (int i = 0; i < 4; i++) begin
          regs_q[i] <= '0;
        end
      end else begin
        pready_q <= pready_d;
        for (int i = 0; i < 4; i++) begin
          regs_q[i] <= regs_d[i];
        end
      end
    end

    assign per_pready[gi] = pready_q;
    assign per_prdata[gi] = regs_q[paddr_q[3:2]];
  end

  // Response mux: anything without a real completer answers at once with 0.
  always_comb begin
    pready_mux = 1'b1;
    prdata_mux = '0;
    if (slot_hit[0]) begin
      pready_mux = psel[0] & penable;
      prdata_mux = ram_mem[ram_idx];
    end else if (slot_hit[1]) begin
      pready_mux = per_pready[0];
      prdata_mux = per_prdata[0];
    end else if (slot_hit[2]) begin
      pready_mux = per_pready[1];
      prdata_mux = per_prdata[1];
    end
  end

  // ---------------------------------------------------------- master FSM
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    case (state_q)
      S_IDLE: begin
        if (transfer) begin
          state_d  = S_SETUP;
          paddr_d  = addr;
          pwrite_d = write;
          pwdata_d = wdata;
        end
      end
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (pready_mux) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= S_IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
    end
  end

  assign ready = (state_q == S_ACCESS) & pready_mux;
  assign rdata = (ready & ~pwrite_q) ? prdata_mux : 32'h0;

  // Address bits that no completer decodes.
  logic unused_paddr_bits;
  assign unused_paddr_bits = ^{paddr_q[11:RAM_AW+2], paddr_q[1:0]};

endmodule

// File: tb/tb_apb_subsystem.sv
// tb_apb_subsystem
//   Drives host requests into apb_subsystem and compares latency, PSEL
//   activity, ready pulse shape and read data against a memory-map model
//   built from the address map and wait-state rules.
module tb_apb_subsystem;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        transfer = 1'b0;
  logic        write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        ready;
  logic [31:0] rdata;

  apb_subsystem #(.RAM_WORDS(16)) dut (
    .PCLK(PCLK),
    .PRESET(PRESET),
    .transfer(transfer),
    .write(write),
    .addr(addr),
    .wdata(wdata),
    .ready(ready),
    .rdata(rdata)
  );

  always #5 PCLK = ~PCLK;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } op_t;

  // Reference model of the visible memory map.
  logic [31:0] ram_m [16];
  logic [31:0] reg_m [3][4];

  function automatic int slot_of(logic [31:0] a);
    logic [31:0] page;
    page = a >> 12;
    if (page >= 32'h10000 && page <= 32'h10004) return int'(page - 32'h10000);
    return -1;
  endfunction

  function automatic int exp_lat(int s);
    return (s == 1 || s == 2) ? 3 : 2;
  endfunction

  function automatic logic [4:0] exp_psel(int s);
    if (s < 0) return 5'b0;
    return 5'(1 << s);
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] a);
    int s;
    s = slot_of(a);
    if (s == 0) return ram_m[(a >> 2) % 16];
    if (s == 1 || s == 2) return reg_m[s][(a >> 2) % 4];
    return 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    int s;
    s = slot_of(a);
    if (s == 0) ram_m[(a >> 2) % 16] = d;
    else if (s == 1 || s == 2) reg_m[s][(a >> 2) % 4] = d;
  endtask

  task automatic model_clear_regs();
    for (int s = 0; s < 3; s++)
      for (int r = 0; r < 4; r++) reg_m[s][r] = 32'h0;
  endtask

  // Issues one request from a negedge with the master idle and returns at a
  // negedge with the master idle again. lat = edges from the sampling edge to
  // ready (-1 on timeout); bad = more than one PSEL at once, ready lasting
  // more than one cycle, or PSEL still high after completion.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output int lat, output logic [31:0] rd,
                      output logic [4:0] ps, output logic bad);
    lat = -1; rd = '0; ps = '0; bad = 1'b0;
    transfer = 1'b1; write = w; addr = a; wdata = d;
    @(posedge PCLK);
    #1 transfer = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge PCLK);
      ps |= dut.psel;
      if ($countones(dut.psel) > 1) bad = 1'b1;
      if (ready) begin
        lat = c;
        rd  = rdata;
        break;
      end
    end
    if (lat > 0) begin
      @(negedge PCLK);
      if (ready || (dut.psel != 5'b0)) bad = 1'b1;
    end
    $display("xfer %s addr=%08h wdata=%08h lat=%0d rdata=%08h psel=%05b",
             w ? "WR" : "RD", a, d, lat, rd, ps);
  endtask

  task automatic test_reset();
    model_clear_regs();
    PRESET = 1'b1;
    repeat (3) @(negedge PCLK);
    total++; if (ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", ready); else passed++;
    total++; if (rdata !== 32'h0) $display("FAIL reset_rdata got=%08h exp=0", rdata); else passed++;
    total++; if (dut.psel !== 5'b0 || dut.penable !== 1'b0)
      $display("FAIL reset_psel_penable got=%05b/%b exp=0/0", dut.psel, dut.penable); else passed++;
    total++; if (dut.paddr_q !== 32'h0 || dut.pwdata_q !== 32'h0 || dut.pwrite_q !== 1'b0)
      $display("FAIL reset_bus got=%08h/%08h/%b exp=0/0/0", dut.paddr_q, dut.pwdata_q, dut.pwrite_q);
    else passed++;
    PRESET = 1'b0;
  endtask

  task automatic test_ram();
    op_t ops[$];
    int lat, s; logic [31:0] rd, exp_rd; logic [4:0] ps; logic bad;
    ops.push_back('{1'b1, 32'h1000_0000, 32'd1});
    ops.push_back('{1'b1, 32'h1000_0004, 32'd2});
    ops.push_back('{1'b1, 32'h1000_0008, 32'd3});
    ops.push_back('{1'b0, 32'h1000_0000, 32'd0});
    ops.push_back('{1'b0, 32'h1000_0004, 32'd0});
    ops.push_back('{1'b0, 32'h1000_0008, 32'd0});
    // Fill every word through random aliases, then read at random aliases.
    for (int i = 0; i < 16; i++)
      ops.push_back('{1'b1, 32'h1000_0000 | ($urandom & 32'hFC3) | (i << 2), $urandom});
    for (int i = 0; i < 16; i++)
      ops.push_back('{1'b0, 32'h1000_0000 | ($urandom & 32'hFFF), $urandom});
    ops.push_back('{1'b1, 32'h1000_0000, 32'hA5});
    ops.push_back('{1'b0, 32'h1000_0040, 32'd0});
    foreach (ops[i]) begin
      s = slot_of(ops[i].a);
      exp_rd = ops[i].w ? 32'h0 : model_read(ops[i].a);
      xfer(ops[i].w, ops[i].a, ops[i].d, lat, rd, ps, bad);
      total++; if (lat !== exp_lat(s)) $display("FAIL ram_latency addr=%08h got=%0d exp=%0d", ops[i].a, lat, exp_lat(s)); else passed++;
      total++; if (ps !== exp_psel(s)) $display("FAIL ram_psel addr=%08h got=%05b exp=%05b", ops[i].a, ps, exp_psel(s)); else passed++;
      total++; if (bad !== 1'b0) $display("FAIL ram_pulse addr=%08h got=%b exp=0", ops[i].a, bad); else passed++;
      total++; if (rd !== exp_rd) $display("FAIL ram_rdata addr=%08h got=%08h exp=%08h", ops[i].a, rd, exp_rd); else passed++;
      if (ops[i].w) model_write(ops[i].a, ops[i].d);
    end
  endtask

  task automatic test_regs();
    op_t ops[$];
    int lat, s; logic [31:0] rd, exp_rd, a; logic [4:0] ps; logic bad;
    ops.push_back('{1'b1, 32'h1000_1000, 32'd11});
    ops.push_back('{1'b1, 32'h1000_2000, 32'd12});
    ops.push_back('{1'b0, 32'h1000_1000, 32'd0});
    ops.push_back('{1'b0, 32'h1000_2000, 32'd0});
    ops.push_back('{1'b0, 32'h1000_1004, 32'd0});
    ops.push_back('{1'b1, 32'h1000_100C, 32'hDEADBEEF});
    ops.push_back('{1'b0, 32'h1000_100C, 32'd0});
    ops.push_back('{1'b0, 32'h1000_2000, 32'd0});
    for (int i = 0; i < 14; i++) begin
      a = (($urandom & 1) != 0 ? 32'h1000_1000 : 32'h1000_2000) | ($urandom & 32'hFFF);
      ops.push_back('{1'($urandom & 1), a, $urandom});
    end
    foreach (ops[i]) begin
      s = slot_of(ops[i].a);
      exp_rd = ops[i].w ? 32'h0 : model_read(ops[i].a);
      xfer(ops[i].w, ops[i].a, ops[i].d, lat, rd, ps, bad);
      total++; if (lat !== exp_lat(s)) $display("FAIL reg_latency addr=%08h got=%0d exp=%0d", ops[i].a, lat, exp_lat(s)); else passed++;
      total++; if (ps !== exp_psel(s)) $display("FAIL reg_psel addr=%08h got=%05b exp=%05b", ops[i].a, ps, exp_psel(s)); else passed++;
      total++; if (bad !== 1'b0) $display("FAIL reg_pulse addr=%08h got=%b exp=0", ops[i].a, bad); else passed++;
      total++; if (rd !== exp_rd) $display("FAIL reg_rdata addr=%08h got=%08h exp=%08h", ops[i].a, rd, exp_rd); else passed++;
      if (ops[i].w) model_write(ops[i].a, ops[i].d);
    end
  endtask

  task automatic test_unmapped();
    op_t ops[$];
    int lat, s; logic [31:0] rd, a; logic [4:0] ps; logic bad;
    ops.push_back('{1'b1, 32'h1000_3000, 32'h1234_5678});
    ops.push_back('{1'b0, 32'h1000_3000, 32'd0});
    ops.push_back('{1'b0, 32'h1000_4ABC, 32'd0});
    ops.push_back('{1'b1, 32'h2000_0000, 32'hCAFE_F00D});
    ops.push_back('{1'b0, 32'h2000_0000, 32'd0});
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      s = slot_of(a);
      if (s >= 0 && s <= 2) a = 32'h3000_0000 | (a & 32'hFFF);
      ops.push_back('{1'($urandom & 1), a, $urandom});
    end
    foreach (ops[i]) begin
      s = slot_of(ops[i].a);
      xfer(ops[i].w, ops[i].a, ops[i].d, lat, rd, ps, bad);
      total++; if (lat !== exp_lat(s)) $display("FAIL unmapped_latency addr=%08h got=%0d exp=%0d", ops[i].a, lat, exp_lat(s)); else passed++;
      total++; if (ps !== exp_psel(s)) $display("FAIL unmapped_psel addr=%08h got=%05b exp=%05b", ops[i].a, ps, exp_psel(s)); else passed++;
      total++; if (bad !== 1'b0) $display("FAIL unmapped_pulse addr=%08h got=%b exp=0", ops[i].a, bad); else passed++;
      total++; if (rd !== 32'h0) $display("FAIL unmapped_rdata addr=%08h got=%08h exp=00000000", ops[i].a, rd); else passed++;
    end
    // Discarded writes must not have reached RAM or the registers.
    xfer(1'b0, 32'h1000_0000, 32'h0, lat, rd, ps, bad);
    total++; if (rd !== ram_m[0]) $display("FAIL unmapped_no_side_effect got=%08h exp=%08h", rd, ram_m[0]); else passed++;
  endtask

  task automatic test_back_to_back();
    int p0, p1, n; logic [31:0] r0, r1, exp_rd;
    p0 = -1; p1 = -1; n = 0; r0 = 'x; r1 = 'x;
    exp_rd = ram_m[0];
    transfer = 1'b1; write = 1'b0; addr = 32'h1000_0000;
    for (int c = 1; c <= 20 && n < 2; c++) begin
      @(negedge PCLK);
      if (ready) begin
        if (n == 0) begin p0 = c; r0 = rdata; end
        else begin p1 = c; r1 = rdata; end
        n++;
      end
    end
    transfer = 1'b0;
    @(negedge PCLK);
    $display("xfer RD-held addr=10000000 pulses=%0d,%0d rdata=%08h,%08h", p0, p1, r0, r1);
    total++; if (p0 !== 2) $display("FAIL b2b_first_latency got=%0d exp=2", p0); else passed++;
    total++; if (p1 - p0 !== 3) $display("FAIL b2b_occupancy got=%0d exp=3", p1 - p0); else passed++;
    total++; if (r0 !== exp_rd || r1 !== exp_rd) $display("FAIL b2b_rdata got=%08h,%08h exp=%08h", r0, r1, exp_rd); else passed++;
    total++; if (ready !== 1'b0 || dut.psel !== 5'b0) $display("FAIL b2b_idle got=%b/%05b exp=0/00000", ready, dut.psel); else passed++;
  endtask

  task automatic test_reset_mid();
    op_t ops[$];
    int lat; logic [31:0] rd, exp_rd; logic [4:0] ps; logic bad, saw_ready;
    transfer = 1'b1; write = 1'b1; addr = 32'h1000_1000; wdata = 32'h55;
    @(posedge PCLK);
    #1 transfer = 1'b0;
    @(negedge PCLK);   // SETUP
    @(negedge PCLK);   // first ACCESS cycle (wait state)
    total++; if (dut.penable !== 1'b1 || dut.psel !== 5'b00010)
      $display("FAIL midrst_in_access got=%b/%05b exp=1/00010", dut.penable, dut.psel); else passed++;
    #1 PRESET = 1'b1;
    #1;
    total++; if (dut.psel !== 5'b0 || dut.penable !== 1'b0)
      $display("FAIL midrst_drop got=%05b/%b exp=00000/0", dut.psel, dut.penable); else passed++;
    saw_ready = ready;
    repeat (3) begin
      @(negedge PCLK);
      saw_ready |= ready;
    end
    PRESET = 1'b0;
    repeat (3) begin
      @(negedge PCLK);
      saw_ready |= ready;
    end
    total++; if (saw_ready !== 1'b0) $display("FAIL midrst_no_ready got=%b exp=0", saw_ready); else passed++;
    $display("xfer WR-aborted addr=10001000 wdata=00000055 ready_seen=%b", saw_ready);
    model_clear_regs();
    ops.push_back('{1'b0, 32'h1000_1000, 32'd0});
    ops.push_back('{1'b0, 32'h1000_2000, 32'd0});
    ops.push_back('{1'b0, 32'h1000_0004, 32'd0});
    foreach (ops[i]) begin
      exp_rd = model_read(ops[i].a);
      xfer(ops[i].w, ops[i].a, ops[i].d, lat, rd, ps, bad);
      total++; if (rd !== exp_rd) $display("FAIL midrst_rdata addr=%08h got=%08h exp=%08h", ops[i].a, rd, exp_rd); else passed++;
      total++; if (lat !== exp_lat(slot_of(ops[i].a))) $display("FAIL midrst_latency addr=%08h got=%0d exp=%0d", ops[i].a, lat, exp_lat(slot_of(ops[i].a))); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_regs();
    test_unmapped();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/apb_subsystem.md
# apb_subsystem

Single-master APB subsystem: a request-driven APB master with a five-slot address decoder and read-data mux, plus three populated completers. The completers are a 16-word RAM at slot 0 and two 4-register peripherals at slots 1 and 2. A host-side request interface (`transfer`/`write`/`addr`/`wdata` → `ready`/`rdata`) drives one APB transaction per request. This block is the bus fabric and test target for the peripheral project.

## Interface
- `RAM_WORDS`, default 16: RAM depth in 32-bit words; indexed by `PADDR[5:2]`.
- `PCLK` in, 1: single system clock; everything is rising-edge.
- `PRESET` in, 1: asynchronous, active-high reset.
- `transfer` in, 1: request strobe; sampled only while the master is in IDLE.
- `write` in, 1: 1 = write, 0 = read; captured with `transfer`.
- `addr` in, 32: byte address; captured with `transfer`.
- `wdata` in, 32: write data; captured with `transfer`.
- `ready` out, 1: transfer complete; 1-cycle pulse.
- `rdata` out, 32: read data; valid only while `ready`=1, otherwise 0.

## Operation
- Address map is decoded from `addr[31:12]`:
  - 0x10000 → slot 0 (RAM)
  - 0x10001 → slot 1 (register peripheral A)
  - 0x10002 → slot 2 (register peripheral B)
  - 0x10003 / 0x10004 → slots 3 and 4, unpopulated
  - anything else → unmapped
- Master FSM has three states: IDLE, SETUP, ACCESS.
  - IDLE: if `transfer`=1 at the edge, latch `addr`/`write`/`wdata` into PADDR/PWRITE/PWDATA and go to SETUP. Otherwise stay.
  - SETUP: decoded PSELx=1, PENABLE=0; unconditionally go to ACCESS.
  - ACCESS: PSELx=1, PENABLE=1. When the muxed PREADY=1, `ready`=1 and `rdata`=muxed PRDATA (reads only; 0 for writes), then go to IDLE. Otherwise stay in ACCESS (wait state).
- PADDR/PWRITE/PWDATA are held stable from SETUP through the completing ACCESS cycle.
- At most one PSELx is high; all are 0 in IDLE.
- Unpopulated slots 3/4 and unmapped addresses:
  - No real completer responds; the mux supplies PREADY=1 and PRDATA=0.
  - The transfer completes with zero wait states and writes are discarded.
  - Slots 3/4 still assert their PSEL. An unmapped address asserts no PSEL.
- RAM (slot 0):
  - Zero wait: PREADY = PSEL & PENABLE.
  - A write stores PWDATA at word `PADDR[5:2]` on the completing edge.
  - Reads are combinational from the array.
  - Contents are not cleared by reset.
  - Byte offset `PADDR[1:0]` is ignored; addresses alias modulo 64 bytes.
- Register peripheral (slots 1, 2):
  - Four 32-bit registers at `PADDR[3:2]`; `PADDR[11:4]` ignored.
  - Exactly one wait state: PREADY is registered and rises in the second ACCESS cycle.
  - A write commits on that completing edge.
  - All registers reset to 0.
- `transfer` held high continuously starts a new transfer each time the FSM revisits IDLE. `transfer` pulses arriving outside IDLE are ignored.

## Timing
- Reset (asynchronous assert, synchronous release):
  - FSM goes to IDLE.
  - PSEL* = 0, PENABLE = 0, PWRITE = 0, PADDR = 0, PWDATA = 0.
  - `ready` = 0, `rdata` = 0.
  - Register peripherals cleared.
- Reset mid-transfer aborts the transfer immediately. No write commits and no `ready` pulse is produced.
- Latency from the edge that samples `transfer` to `ready` high:
  - RAM, slots 3/4, unmapped: 2 cycles (SETUP, ACCESS).
  - Register peripherals: 3 cycles.
- Per-transfer occupancy is one cycle longer than that latency, because IDLE is revisited between transfers.
- `ready` and `rdata` are combinational from FSM state and slave outputs. `ready` is high for exactly one cycle.

## Test plan
- Reset, then write 1/2/3 to 0x1000_0000/04/08 and read back the same addresses:
  - Each `ready` comes 2 cycles after `transfer` is sampled.
  - Reads return 1, 2, 3.
  - Only PSEL0 toggles.
- Write 11 to 0x1000_1000 and 12 to 0x1000_2000, then read both back:
  - `ready` arrives 3 cycles after sampling.
  - Reads return 11 and 12.
  - PSEL1 and PSEL2 are each exclusive for their own accesses.
- Read 0x1000_1004 after reset → `rdata`=0. Write 0xDEADBEEF to 0x1000_100C, read 0x1000_100C → 0xDEADBEEF; 0x1000_2000 is unaffected.
- Read 0x1000_0040 after writing 0xA5 to 0x1000_0000 → 0xA5 (RAM alias).
- Access 0x1000_3000 and 0x2000_0000:
  - `ready` arrives 2 cycles after sampling, `rdata`=0.
  - PSEL3 asserts for the first access; no PSEL asserts for the second.
- Assert `PRESET` during ACCESS of a register write of 0x55 to 0x1000_1000:
  - PSEL/PENABLE drop immediately and `ready` never pulses.
  - A subsequent read of 0x1000_1000 returns 0.
